// File: rtl/plic_lite_if.sv
// plic_lite_if: word-wide valid/ready bus into the PLIC register window.
// master: mem_valid/wstrb/addr/wdata out; slave: one-cycle mem_ready + rdata.
interface plic_lite_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_wstrb;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_wstrb, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_wstrb, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/plic_lite.sv
// plic_lite: priority interrupt controller, ctx0 -> irq_meip, ctx1 -> irq_seip.
// Ports: clk, resetn (async low), src_irq[N-1:0], bus (slave), irq_meip, irq_seip.
// Optional PLIC_EDGE_EN: per-source edge-select register at 0x001080.
module plic_lite #(
  parameter int NUM_SOURCES = 8,
  parameter int PRIO_BITS   = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_SOURCES-1:0] src_irq,
  plic_lite_if.slave             bus,
  output logic                   irq_meip,
  output logic                   irq_seip
);

  localparam int N = NUM_SOURCES;
  localparam logic [4:0] NS5 = 5'(N);

  typedef logic [PRIO_BITS-1:0] prio_t;

  localparam logic [19:0] W_PEND  = 20'h00400;
  localparam logic [19:0] W_EDGE  = 20'h00420;
  localparam logic [19:0] W_EN0   = 20'h00800;
  localparam logic [19:0] W_EN1   = 20'h00820;
  localparam logic [19:0] W_THR0  = 20'h80000;
  localparam logic [19:0] W_CLM0  = 20'h80001;
  localparam logic [19:0] W_THR1  = 20'h80400;
  localparam logic [19:0] W_CLM1  = 20'h80401;

  logic        ready_q, ready_d;
  logic [19:0] waddr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;

  prio_t       prio_q [1:N];
  prio_t       prio_d [1:N];
  logic [N:1]  pend_q, pend_d;
  logic [N:1]  infl_q, infl_d;
  logic [N:1]  en0_q, en0_d;
  logic [N:1]  en1_q, en1_d;
  prio_t       thr0_q, thr0_d;
  prio_t       thr1_q, thr1_d;
  logic        meip_q, seip_q;

  logic [N:1]  src;
  logic [N:1]  set;
  logic [4:0]  best0, best1;
  prio_t       bp0, bp1;

  logic        wr, rd;
  logic [4:0]  id5;
  logic        hit_prio, hit_pend, hit_en0, hit_en1;
  logic        hit_thr0, hit_clm0, hit_thr1, hit_clm1;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign src = src_irq;

`ifdef PLIC_EDGE_EN
  logic [N:1] edge_q, edge_d;
  logic [N:1] prev_q;
  logic       hit_edge;

  assign hit_edge = (waddr_q == W_EDGE);
  // edge sources ignore in_flight; level sources are gated by it
  assign set = (edge_q & src & ~prev_q)
             | (~edge_q & src & ~infl_q);
`else
  assign set = src & ~infl_q;
`endif

  assign wr  = ready_q && (wstrb_q == 4'hF);
  assign rd  = ready_q && (wstrb_q == 4'h0);
  assign id5 = waddr_q[4:0];

  assign hit_prio = (waddr_q[19:5] == '0)
                 && (id5 != '0) && (id5 <= NS5);
  assign hit_pend = (waddr_q == W_PEND);
  assign hit_en0  = (waddr_q == W_EN0);
  assign hit_en1  = (waddr_q == W_EN1);
  assign hit_thr0 = (waddr_q == W_THR0);
  assign hit_clm0 = (waddr_q == W_CLM0);
  assign hit_thr1 = (waddr_q == W_THR1);
  assign hit_clm1 = (waddr_q == W_CLM1);

  assign unused_bits = ^{wdata_q, bus.mem_addr[1:0]};

  // strict '>' keeps the lowest ID on ties; starting at the
  // threshold makes priority 0 and sub-threshold IDs never win
  always_comb begin
    best0 = '0;
    best1 = '0;
    bp0   = thr0_q;
    bp1   = thr1_q;
    for (int i = 1; i <= N; i++) begin
      if (pend_q[i] && en0_q[i] && prio_q[i] > bp0) begin
        bp0   = prio_q[i];
        best0 = 5'(i);
      end
      if (pend_q[i] && en1_q[i] && prio_q[i] > bp1) begin
        bp1   = prio_q[i];
        best1 = 5'(i);
      end
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      hit_prio: begin
        for (int i = 1; i <= N; i++)
          if (id5 == 5'(i)) rd_val = 32'(prio_q[i]);
      end
      hit_pend: rd_val = 32'({pend_q, 1'b0});
`ifdef PLIC_EDGE_EN
      hit_edge: rd_val = 32'({edge_q, 1'b0});
`endif
      hit_en0:  rd_val = 32'({en0_q, 1'b0});
      hit_en1:  rd_val = 32'({en1_q, 1'b0});
      hit_thr0: rd_val = 32'(thr0_q);
      hit_clm0: rd_val = 32'(best0);
      hit_thr1: rd_val = 32'(thr1_q);
      hit_clm1: rd_val = 32'(best1);
      default:  rd_val = '0;
    endcase
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = ready_q ? rd_val : '0;
  assign irq_meip      = meip_q;
  assign irq_seip      = seip_q;

  always_comb begin
    ready_d = bus.mem_valid && !ready_q;
    prio_d  = prio_q;
    pend_d  = pend_q | set;
    infl_d  = infl_q;
    en0_d   = en0_q;
    en1_d   = en1_q;
    thr0_d  = thr0_q;
    thr1_d  = thr1_q;
`ifdef PLIC_EDGE_EN
    edge_d  = edge_q;
`endif

    if (wr) begin
      unique case (1'b1)
        hit_prio: begin
          for (int i = 1; i <= N; i++)
            if (id5 == 5'(i))
              prio_d[i] = wdata_q[PRIO_BITS-1:0];
        end
`ifdef PLIC_EDGE_EN
        hit_edge: edge_d = wdata_q[N:1];
`endif
        hit_en0:  en0_d  = wdata_q[N:1];
        hit_en1:  en1_d  = wdata_q[N:1];
        hit_thr0: thr0_d = wdata_q[PRIO_BITS-1:0];
        hit_thr1: thr1_d = wdata_q[PRIO_BITS-1:0];
        hit_clm0: begin
          for (int i = 1; i <= N; i++)
            if (wdata_q[4:0] == 5'(i) && en0_q[i])
              infl_d[i] = 1'b0;
        end
        hit_clm1: begin
          for (int i = 1; i <= N; i++)
            if (wdata_q[4:0] == 5'(i) && en1_q[i])
              infl_d[i] = 1'b0;
        end
        default: ;
      endcase
    end

    // claim overrides a same-cycle gateway set
    if (rd && (hit_clm0 || hit_clm1)) begin
      for (int i = 1; i <= N; i++) begin
        if ((hit_clm0 && best0 == 5'(i)) ||
            (hit_clm1 && best1 == 5'(i))) begin
          pend_d[i] = 1'b0;
          infl_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      waddr_q <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      for (int i = 1; i <= N; i++) prio_q[i] <= '0;
      pend_q  <= '0;
      infl_q  <= '0;
      en0_q   <= '0;
      en1_q   <= '0;
      thr0_q  <= '0;
      thr1_q  <= '0;
      meip_q  <= 1'b0;
      seip_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      if (ready_d) begin
        waddr_q <= bus.mem_addr[21:2];
        wstrb_q <= bus.mem_wstrb;
        wdata_q <= bus.mem_wdata;
      end
      prio_q  <= prio_d;
      pend_q  <= pend_d;
      infl_q  <= infl_d;
      en0_q   <= en0_d;
      en1_q   <= en1_d;
      thr0_q  <= thr0_d;
      thr1_q  <= thr1_d;
      meip_q  <= (best0 != '0);
      seip_q  <= (best1 != '0);
    end
  end

`ifdef PLIC_EDGE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      edge_q <= '0;
      prev_q <= '0;
    end else begin
      edge_q <= edge_d;
      prev_q <= src;
    end
  end
`endif

endmodule

// File: tb/tb_plic_lite.sv
// tb_plic_lite: scoreboard bench for plic_lite with a
// register-level reference model and randomized traffic.
module tb_plic_lite;
  localparam int N  = 8;
  localparam int PB = 3;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] src_irq = '0;
  logic         irq_meip, irq_seip;

  plic_lite_if bus ();

  plic_lite #(.NUM_SOURCES(N), .PRIO_BITS(PB)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .src_irq  (src_irq),
    .bus      (bus),
    .irq_meip (irq_meip),
    .irq_seip (irq_seip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int          m_prio [N+1];
  logic [N:0]  m_pend, m_infl, m_edge;
  logic [N:0]  m_en [2];
  int          m_thr [2];
  logic [31:0] expq [$];

  function automatic void check(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i <= N; i++) m_prio[i] = 0;
    m_pend = '0; m_infl = '0; m_edge = '0;
    m_en[0] = '0; m_en[1] = '0;
    m_thr[0] = 0; m_thr[1] = 0;
  endfunction

  function automatic bit qual(int c, int i);
    return m_pend[i] && m_en[c][i] && (m_prio[i] > m_thr[c]);
  endfunction

  // highest qualifying priority first, then lowest ID holding it
  function automatic int model_best(int c);
    int mx = 0;
    for (int i = 1; i <= N; i++)
      if (qual(c, i) && m_prio[i] > mx) mx = m_prio[i];
    if (mx == 0) return 0;
    for (int i = 1; i <= N; i++)
      if (qual(c, i) && m_prio[i] == mx) return i;
    return 0;
  endfunction

  function automatic void model_settle();
    for (int i = 1; i <= N; i++)
      if (src_irq[i-1] && !m_infl[i] && !m_edge[i]) m_pend[i] = 1'b1;
  endfunction

  function automatic logic [31:0] model_access(int addr,
                                                logic [3:0] strb,
                                                logic [31:0] wd);
    int a = addr & ~3;
    int c, id;
    logic [31:0] r = '0;
    bit do_rd = (strb == 4'h0);
    bit do_wr = (strb == 4'hF);
    if (a < 'h1000) begin
      id = a / 4;
      if (id >= 1 && id <= N) begin
        r = 32'(m_prio[id]);
        if (do_wr) m_prio[id] = int'(wd) & ((1 << PB) - 1);
      end
    end else if (a == 'h1000) begin
      r = 32'(m_pend);
    end else if (a == 'h1080) begin
`ifdef PLIC_EDGE_EN
      r = 32'(m_edge);
      if (do_wr) m_edge = {wd[N:1], 1'b0};
`endif
    end else if (a == 'h2000 || a == 'h2080) begin
      c = (a == 'h2080) ? 1 : 0;
      r = 32'(m_en[c]);
      if (do_wr) m_en[c] = {wd[N:1], 1'b0};
    end else if (a == 'h200000 || a == 'h201000) begin
      c = (a == 'h201000) ? 1 : 0;
      r = 32'(m_thr[c]);
      if (do_wr) m_thr[c] = int'(wd) & ((1 << PB) - 1);
    end else if (a == 'h200004 || a == 'h201004) begin
      c = (a == 'h201004) ? 1 : 0;
      id = model_best(c);
      r = 32'(id);
      if (do_rd && id != 0) begin
        m_pend[id] = 1'b0;
        m_infl[id] = 1'b1;
      end
      if (do_wr) begin
        id = int'(wd[4:0]);
        if (id >= 1 && id <= N && m_en[c][id]) m_infl[id] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_txn(int addr, logic [3:0] strb,
                         logic [31:0] wd, bit use_exp,
                         logic [31:0] exp);
    logic [31:0] mv, tmp;
    bit got = 0;
    mv = model_access(addr, strb, wd);
    if (strb == 4'h0) expq.push_back(use_exp ? exp : mv);
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 22'(addr);
    bus.mem_wstrb = strb;
    bus.mem_wdata = wd;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.mem_ready) got = 1;
    end
    if (!got) begin
      checks++;
      $display("FAIL bus_timeout: addr %0h no ready within 8 cycles", addr);
      if (strb == 4'h0 && expq.size() > 0) tmp = expq.pop_back();
    end
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    idle(3);
    model_settle();
  endtask

  task automatic wr(int a, logic [31:0] d);
    bus_txn(a, 4'hF, d, 0, '0);
  endtask

  task automatic rd_exp(int a, logic [31:0] e);
    bus_txn(a, 4'h0, '0, 1, e);
  endtask

  task automatic rd_model(int a);
    bus_txn(a, 4'h0, '0, 0, '0);
  endtask

  task automatic check_irqs(string tag);
    check({tag, "_meip"}, 32'(irq_meip), 32'(model_best(0) != 0));
    check({tag, "_seip"}, 32'(irq_seip), 32'(model_best(1) != 0));
  endtask

  always @(negedge clk) begin
    if (resetn && bus.mem_ready && bus.mem_wstrb == 4'h0) begin
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL rdata: got %0h expected none queued", bus.mem_rdata);
      end else begin
        check("rdata", bus.mem_rdata, expq.pop_front());
      end
    end
  end

  int regs [12] = '{'h1000, 'h2000, 'h2080, 'h200000, 'h200004,
                    'h201000, 'h201004, 'h1080, 'h3000, 'h7c,
                    'h20, 'h0};

  initial begin
    int op, c, id, a;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    model_reset();

    #1;
    check("reset_meip", 32'(irq_meip), 0);
    check("reset_seip", 32'(irq_seip), 0);
    check("reset_ready", 32'(bus.mem_ready), 0);
    check("reset_rdata", bus.mem_rdata, 0);
    idle(2);
    resetn = 1'b1;
    rd_exp('h1000, 0);
    rd_exp('h200004, 0);

    wr('hC, 2);
    wr('h2000, 'h08);
    wr('h200000, 1);
    @(posedge clk); #1;
    src_irq[2] = 1'b1;
    @(posedge clk); #1;
    check("lat1_meip", 32'(irq_meip), 0);
    @(posedge clk); #1;
    check("lat2_meip", 32'(irq_meip), 1);
    check("lat2_seip", 32'(irq_seip), 0);
    model_settle();

    rd_exp('h200004, 3);
    rd_exp('h1000, 0);
    check("claimed_meip", 32'(irq_meip), 0);
    idle(4);
    model_settle();
    rd_exp('h1000, 0);
    wr('h200004, 3);
    rd_exp('h1000, 'h08);
    check("repend_meip", 32'(irq_meip), 1);

    wr('h8, 5);
    wr('h14, 5);
    wr('h18, 7);
    wr('h2080, 'h64);
    @(posedge clk); #1;
    src_irq = src_irq | 8'h32;
    idle(3);
    model_settle();
    rd_exp('h201004, 6);
    rd_exp('h201004, 2);
    rd_exp('h201004, 5);
    rd_exp('h201004, 0);

    wr('h201004, 2);
    wr('h201000, 5);
    check("thr5_seip", 32'(irq_seip), 0);
    rd_exp('h201004, 0);
    wr('h201000, 4);
    check("thr4_seip", 32'(irq_seip), 1);

    bus_txn('h201000, 4'h3, 7, 0, '0);
    rd_exp('h201000, 4);
    rd_exp('h3000, 0);
    wr('h0, 7);
    rd_exp('h0, 0);
    wr('h2000, 32'hFFFF_FFFF);
    rd_exp('h2000, 'h1FE);
    wr('h2000, 'h08);
`ifndef PLIC_EDGE_EN
    wr('h1080, 'hFF);
    rd_exp('h1080, 0);
`endif

    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 8);
      c  = $urandom_range(0, 1);
      case (op)
        0: begin
          @(posedge clk); #1;
          src_irq = N'($urandom);
          idle(3);
          model_settle();
        end
        1: begin
          id = $urandom_range(0, N + 1);
          wr(4 * id + $urandom_range(0, 3), $urandom);
        end
        2: wr(c ? 'h2080 : 'h2000, $urandom);
        3: wr(c ? 'h201000 : 'h200000, $urandom_range(0, 7));
        4, 5: rd_model(c ? 'h201004 : 'h200004);
        6: begin
          id = $urandom_range(0, N + 2);
          wr(c ? 'h201004 : 'h200004,
             {$urandom_range(0, 255), 19'h0, 5'(id)});
        end
        7: begin
          a = regs[$urandom_range(0, 11)];
          rd_model(a + $urandom_range(0, 3));
        end
        default: begin
          a = regs[$urandom_range(0, 11)];
          bus_txn(a, 4'($urandom_range(1, 14)), $urandom, 0, '0);
        end
      endcase
      check_irqs("rand");
    end

    wr('h2000, 'hFE);
    wr('h200000, 0);
    @(posedge clk); #1;
    src_irq = '1;
    idle(3);
    model_settle();
    rd_model('h200004);
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 22'h200004;
    bus.mem_wstrb = 4'h0;
    @(posedge clk); #3;
    resetn = 1'b0;
    bus.mem_valid = 1'b0;
    src_irq = '0;
    #1;
    check("async_ready", 32'(bus.mem_ready), 0);
    check("async_rdata", bus.mem_rdata, 0);
    check("async_meip", 32'(irq_meip), 0);
    check("async_seip", 32'(irq_seip), 0);
    idle(2);
    resetn = 1'b1;
    model_reset();
    rd_exp('h200004, 0);
    rd_exp('h1000, 0);
    rd_exp('hC, 0);
    rd_exp('h2000, 0);
    rd_exp('h201000, 0);

`ifdef PLIC_EDGE_EN
    wr('h10, 3);
    wr('h2000, 'h10);
    wr('h1080, 'h10);
    rd_exp('h1080, 'h10);
    @(posedge clk); #1;
    src_irq[3] = 1'b1;
    @(posedge clk); #1;
    src_irq[3] = 1'b0;
    m_pend[4] = 1'b1;
    idle(3);
    rd_exp('h1000, 'h10);
    rd_exp('h200004, 4);
    @(posedge clk); #1;
    src_irq[3] = 1'b1;
    @(posedge clk); #1;
    src_irq[3] = 1'b0;
    m_pend[4] = 1'b1;
    idle(3);
    rd_exp('h1000, 'h10);
    check("edge_meip", 32'(irq_meip), 1);
`endif

    idle(4);
    check("queue_drained", 32'(expq.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
